// File: rtl/memory_stage_if.sv
// Data-memory request/response bundle between the memory stage and
// the data memory.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_wren;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wren, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wren, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU ops through, runs lw/sw as a
// blocking request/ack handshake with a timeout watchdog.
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [31:0]    IR_in,
    input  logic [31:0]    O_in,
    input  logic [31:0]    B_in,
    input  logic           mw_bypass,
    input  logic [31:0]    wb_data,
    memory_stage_if.master mem,
    output logic [31:0]    IR_out,
    output logic [31:0]    O_out,
    output logic [31:0]    D_out,
    output logic           out_valid,
    output logic           stall,
    output logic           mem_err
);

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;
    // Counter value in the last BUSY cycle before forced completion.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [31:0]   ir_q, o_q;
    logic [CW-1:0] cnt;
    logic          is_mem, capture, acked, expired;

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        capture = 1'b0;
        acked   = 1'b0;
        expired = 1'b0;
        is_mem  = in_valid &&
                  (IR_in[31:27] == OP_LW || IR_in[31:27] == OP_SW);
        unique case (state)
            IDLE: begin
                if (is_mem) begin
                    stall   = 1'b1;
                    capture = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                acked   = mem.mem_ack;
                expired = !mem.mem_ack && (cnt == LAST);
                stall   = !(acked || expired);
                if (!stall) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem.mem_req   <= 1'b0;
            mem.mem_wren  <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            ir_q          <= '0;
            o_q           <= '0;
            cnt           <= '0;
            IR_out        <= '0;
            O_out         <= '0;
            D_out         <= '0;
            out_valid     <= 1'b0;
            mem_err       <= 1'b0;
        end else if (state == IDLE) begin
            out_valid <= in_valid && !is_mem;
            if (!in_valid) begin
                IR_out <= '0;
            end else if (!is_mem) begin
                IR_out <= IR_in;
                O_out  <= O_in;
                D_out  <= '0;
            end
            // Store data is frozen here; later bypass changes are moot.
            if (capture) begin
                ir_q          <= IR_in;
                o_q           <= O_in;
                mem.mem_addr  <= O_in[11:0];
                mem.mem_wren  <= (IR_in[31:27] == OP_SW);
                mem.mem_wdata <= mw_bypass ? wb_data : B_in;
                mem.mem_req   <= 1'b1;
                cnt           <= '0;
            end
        end else if (!stall) begin
            mem.mem_req <= 1'b0;
            IR_out      <= ir_q;
            O_out       <= o_q;
            D_out       <= (acked && ir_q[31:27] == OP_LW) ?
                           mem.mem_rdata : '0;
            out_valid   <= 1'b1;
            if (expired) mem_err <= 1'b1;
        end else begin
            cnt       <= cnt + 1'b1;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level model
// with scheduled completion events.
module tb_memory_stage;
    localparam int TMO = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        mw_bypass = 1'b0;
    logic [31:0] IR_in = '0;
    logic [31:0] O_in = '0;
    logic [31:0] B_in = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] IR_out, O_out, D_out;
    logic        out_valid, stall, mem_err;

    memory_stage_if mif();

    memory_stage #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .IR_in(IR_in), .O_in(O_in), .B_in(B_in),
        .mw_bypass(mw_bypass), .wb_data(wb_data), .mem(mif),
        .IR_out(IR_out), .O_out(O_out), .D_out(D_out),
        .out_valid(out_valid), .stall(stall), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          v;
        logic [31:0] ir, o, b, wb, rd;
        bit          byp;
        int          dly;
    } instr_t;

    typedef struct {
        logic [31:0] ir, o, wdata, rdata;
        logic [11:0] addr;
        bit          lw, wren;
        int          start, ack;
    } txn_t;

    instr_t      plan[$];
    instr_t      cur;
    txn_t        pend;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    bit          pend_on = 0, hold = 0, rst_req = 0;
    bit          exp_valid = 0, exp_nop = 0, exp_rst = 1, exp_err = 0;
    logic [31:0] exp_ir, exp_o, exp_d;
    int          stray = -1;
    int          run = 0, last_run = 0, max_run = 0;
    int          busy_cnt = 0, valid_cnt = 0;
    logic [31:0] last_d, last_o, last_wd;
    logic [11:0] last_addr;
    logic        last_wren;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit mem_op(logic [31:0] ir);
        return ir[31:27] == 5'b01000 || ir[31:27] == 5'b00111;
    endfunction

    function automatic instr_t mk(bit v, logic [4:0] op,
                                  logic [31:0] o, logic [31:0] b,
                                  bit byp, logic [31:0] wb,
                                  int dly, logic [31:0] rd);
        instr_t e;
        logic [26:0] lo;
        lo    = 27'($urandom);
        e.v   = v;
        e.ir  = {op, lo};
        e.o   = o;
        e.b   = b;
        e.byp = byp;
        e.wb  = wb;
        e.dly = dly;
        e.rd  = rd;
        return e;
    endfunction

    task automatic complete(logic [31:0] d);
        exp_valid = 1;
        exp_ir    = pend.ir;
        exp_o     = pend.o;
        exp_d     = d;
        pend_on   = 0;
    endtask

    task automatic cycle();
        bit ismem, done, st;
        @(posedge clock);
        #1;
        cyc++;
        if (!hold) begin
            if (plan.size() > 0) begin
                cur = plan.pop_front();
            end else begin
                cur = mk(0, 5'($urandom), $urandom, $urandom, 0,
                         $urandom, 0, 0);
            end
            in_valid  = cur.v;
            IR_in     = cur.ir;
            O_in      = cur.o;
            B_in      = cur.b;
            mw_bypass = cur.byp;
            wb_data   = cur.wb;
        end else begin
            mw_bypass = ~cur.byp;
            wb_data   = $urandom;
        end
        reset   = rst_req;
        rst_req = 0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = $urandom;
        if (pend_on) begin
            if (cyc == pend.ack) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = pend.rdata;
            end
        end else if (cyc == stray || $urandom_range(7) == 0) begin
            mif.mem_ack = 1'b1;
        end

        @(negedge clock);
        ismem = in_valid && mem_op(IR_in);
        done  = pend_on &&
                (cyc == pend.ack || cyc == pend.start + TMO - 1);
        st    = pend_on ? !done : ismem;
        if (!reset) chk("stall", 32'(stall), 32'(st));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("mem_err", 32'(mem_err), 32'(exp_err));
        chk("mem_req", 32'(mif.mem_req), 32'(pend_on));
        if (exp_valid) begin
            chk("IR_out", IR_out, exp_ir);
            chk("O_out", O_out, exp_o);
            chk("D_out", D_out, exp_d);
        end
        if (exp_nop) chk("nop_IR_out", IR_out, 32'h0);
        if (exp_rst) begin
            chk("rst_IR_out", IR_out, 32'h0);
            chk("rst_O_out", O_out, 32'h0);
            chk("rst_D_out", D_out, 32'h0);
            chk("rst_addr", 32'(mif.mem_addr), 32'h0);
            chk("rst_wren", 32'(mif.mem_wren), 32'h0);
            chk("rst_wdata", mif.mem_wdata, 32'h0);
        end
        if (pend_on) begin
            chk("mem_addr", 32'(mif.mem_addr), 32'(pend.addr));
            chk("mem_wren", 32'(mif.mem_wren), 32'(pend.wren));
            chk("mem_wdata", mif.mem_wdata, pend.wdata);
        end

        if (stall === 1'b1) begin
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        if (run > max_run) max_run = run;
        if (mif.mem_req === 1'b1) begin
            busy_cnt++;
            last_addr = mif.mem_addr;
            last_wren = mif.mem_wren;
            last_wd   = mif.mem_wdata;
        end
        if (out_valid === 1'b1) begin
            valid_cnt++;
            last_d = D_out;
            last_o = O_out;
        end

        hold    = !reset && st;
        exp_rst = 0;
        exp_nop = 0;
        if (reset) begin
            if (pend_on) stray = pend.ack;
            pend_on   = 0;
            exp_valid = 0;
            exp_err   = 0;
            exp_rst   = 1;
        end else if (pend_on) begin
            if (cyc == pend.ack) begin
                complete(pend.lw ? pend.rdata : 32'h0);
            end else if (cyc == pend.start + TMO - 1) begin
                complete(32'h0);
                exp_err = 1;
            end else begin
                exp_valid = 0;
            end
        end else if (!in_valid) begin
            exp_valid = 0;
            exp_nop   = 1;
        end else if (ismem) begin
            pend_on    = 1;
            pend.ir    = IR_in;
            pend.o     = O_in;
            pend.lw    = IR_in[31:27] == 5'b01000;
            pend.wren  = !pend.lw;
            pend.addr  = O_in[11:0];
            pend.wdata = mw_bypass ? wb_data : B_in;
            pend.rdata = cur.rd;
            pend.start = cyc + 1;
            pend.ack   = cur.dly < 0 ? -1 : cyc + 1 + cur.dly;
            exp_valid  = 0;
        end else begin
            exp_valid = 1;
            exp_ir    = IR_in;
            exp_o     = O_in;
            exp_d     = 32'h0;
        end
    endtask

    task automatic run_idle(int lim);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while ((plan.size() > 0 || pend_on || hold) && k < lim);
        if (plan.size() > 0 || pend_on || hold) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: no idle after %0d cycles", lim);
        end
        repeat (2) cycle();
    endtask

    task automatic clr_obs();
        run = 0; last_run = 0; max_run = 0;
        busy_cnt = 0; valid_cnt = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] op;
        int r, dly;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        rst_req = 1;
        cycle();
        repeat (2) cycle();

        clr_obs();
        plan.push_back(mk(1, 5'b00000, 32'h55, 32'h0, 0, 0, 0, 0));
        run_idle(20);
        chk("add_O_out", last_o, 32'h55);
        chk("add_stall_max", 32'(max_run), 32'd0);
        chk("add_valid_cnt", 32'(valid_cnt), 32'd1);

        clr_obs();
        plan.push_back(mk(1, 5'b01000, 32'h0000_0ABC, 32'h0, 0, 0,
                          3, 32'hDEAD_BEEF));
        run_idle(40);
        chk("lw_D_out", last_d, 32'hDEAD_BEEF);
        chk("lw_stall_run", 32'(last_run), 32'd4);
        chk("lw_addr", 32'(last_addr), 32'hABC);
        chk("lw_wren", 32'(last_wren), 32'd0);
        chk("lw_busy", 32'(busy_cnt), 32'd4);

        clr_obs();
        plan.push_back(mk(1, 5'b00111, 32'h0000_0123, 32'h11, 1,
                          32'h22, 4, 0));
        run_idle(40);
        chk("sw_wdata", last_wd, 32'h22);
        chk("sw_wren", 32'(last_wren), 32'd1);
        chk("sw_busy", 32'(busy_cnt), 32'd5);
        chk("sw_D_out", last_d, 32'h0);

        clr_obs();
        plan.push_back(mk(1, 5'b01000, 32'h10, 32'h0, 0, 0,
                          TMO - 1, 32'h1234_5678));
        run_idle(400);
        chk("edge_D_out", last_d, 32'h1234_5678);
        chk("edge_busy", 32'(busy_cnt), 32'd255);
        chk("edge_err", 32'(mem_err), 32'd0);

        clr_obs();
        plan.push_back(mk(1, 5'b01000, 32'h20, 32'h0, 0, 0,
                          -1, 32'hCAFE_F00D));
        run_idle(400);
        chk("to_busy", 32'(busy_cnt), 32'd255);
        chk("to_D_out", last_d, 32'h0);
        chk("to_valid_cnt", 32'(valid_cnt), 32'd1);
        plan.push_back(mk(1, 5'b00001, 32'h7, 32'h0, 0, 0, 0, 0));
        run_idle(20);
        chk("to_err_sticky", 32'(mem_err), 32'd1);

        plan.push_back(mk(1, 5'b00111, 32'h44, 32'h99, 0, 0, 5, 0));
        cycle();
        cycle();
        rst_req = 1;
        cycle();
        clr_obs();
        repeat (8) cycle();
        chk("rst_no_valid", 32'(valid_cnt), 32'd0);
        chk("rst_req_low", 32'(mif.mem_req), 32'd0);
        chk("rst_err_clr", 32'(mem_err), 32'd0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            dly = $urandom_range(0, 6);
            if ($urandom_range(0, 99) < 3) dly = -1;
            else if ($urandom_range(0, 99) < 3)
                dly = 250 + $urandom_range(0, 6);
            if (r < 20) begin
                op = 5'($urandom);
                plan.push_back(mk(0, op, $urandom, $urandom, 0,
                                  $urandom, 0, 0));
            end else if (r < 55) begin
                do op = 5'($urandom); while (op == 5'd7 || op == 5'd8);
                plan.push_back(mk(1, op, $urandom, $urandom,
                                  1'($urandom), $urandom, 0, 0));
            end else begin
                op = (r < 78) ? 5'b01000 : 5'b00111;
                plan.push_back(mk(1, op, $urandom, $urandom,
                                  1'($urandom), $urandom, dly,
                                  $urandom));
            end
        end
        run_idle(30000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
